// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and default timing constants for the touch-key LED path
package key_pkg;
   typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH} led_st_t;
   localparam int BLINK_CYC_DEF  = 5_000_000;
   localparam int ON_BLINKS_DEF  = 2;
   localparam int OFF_BLINKS_DEF = 1;
endpackage

// File: rtl/key_led_ind_sync_edge.sv
// sync_edge: 2-flop synchroniser with any-edge flag and direction of the change
module sync_edge (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic din,
   output logic lvl,
   output logic edg,
   output logic dir
);
   logic s0, s1;
   always_ff @(posedge clk_50m or negedge rst_n)
      if (!rst_n) {s0, s1} <= 2'b00;
      else        {s0, s1} <= {din, s0};
   assign lvl = s1;
   assign edg = s0 ^ s1;
   assign dir = s0;
endmodule

// File: rtl/key_led_ind.sv
// key_led_ind: plays a blink pattern on each enable-level change, then holds the LED at the new level
module key_led_ind
   import key_pkg::*;
#(
   parameter int BLINK_CYC  = BLINK_CYC_DEF,
   parameter int ON_BLINKS  = ON_BLINKS_DEF,
   parameter int OFF_BLINKS = OFF_BLINKS_DEF
) (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic en_lvl,
   output logic led,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(BLINK_CYC);
   led_st_t st, st_n;
   logic [CW-1:0] ph, ph_n;
   logic [2:0] bl, bl_n;
   logic s1, edg, dir, tgt, tgt_n, go, dir_n, ph_end, led_n, done_n;
   sync_edge u_sync (.clk_50m(clk_50m), .rst_n(rst_n), .din(en_lvl), .lvl(s1), .edg(edg), .dir(dir));
   assign ph_end = ph == CW'(BLINK_CYC - 1);
   // an edge swallowed by pattern completion leaves s1 differing from the latched target
   assign go = edg | (st == IDLE && s1 != tgt);
   assign dir_n = edg ? dir : s1;
   always_comb begin
      st_n = st;
      ph_n = ph;
      bl_n = bl;
      tgt_n = tgt;
      done_n = 1'b0;
      if (st != IDLE) ph_n = ph_end ? '0 : ph + 1'b1;
      if (st == ON_PH && ph_end) st_n = OFF_PH;
      if (st == OFF_PH && ph_end) begin
         bl_n = bl - 3'd1;
         done_n = bl == 3'd1;
         st_n = done_n ? IDLE : ON_PH;
      end
      if (go && !done_n) begin
         st_n = ON_PH;
         ph_n = '0;
         bl_n = dir_n ? 3'(ON_BLINKS) : 3'(OFF_BLINKS);
         tgt_n = dir_n;
      end
      led_n = st_n == ON_PH ? 1'b1 : st_n == OFF_PH ? 1'b0 : s1;
   end
   always_ff @(posedge clk_50m or negedge rst_n)
      if (!rst_n) begin
         st <= IDLE;
         ph <= '0;
         bl <= '0;
         tgt <= 1'b0;
         led <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         st <= st_n;
         ph <= ph_n;
         bl <= bl_n;
         tgt <= tgt_n;
         led <= led_n;
         busy <= st_n != IDLE;
         done <= done_n;
      end
endmodule
